// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: instruction-memory request/response bus between the
// IF-stage fetch sequencer (master) and the instruction memory (slave).
// Exactly one request is outstanding at a time; the strobe is one cycle wide
// and the response arrives one or more cycles later.
interface fetch_redirect_unit_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_valid;
    logic [31:0]       i_imem_data;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_valid,
        input  i_imem_data
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_valid,
        output i_imem_data
    );
endinterface

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: IF-stage program counter and fetch sequencer.
// Issues one instruction-memory request at a time, fills the IF/ID register,
// and on a taken branch resolved in ID redirects the PC to branch PC + offset,
// flushing IF/ID and discarding whatever fetch is still in flight.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_RST  | first cycle out of reset, no request yet
// S_REQ  | request strobe driven for r_pc (exactly one cycle)
// S_WAIT | request outstanding, waiting for its response
// S_HOLD | response parked in the skid register, IF/ID still occupied
// S_KILL | outstanding response belongs to a flushed path; drop it on arrival
module fetch_redirect_unit #(
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,

    fetch_redirect_unit_if.master imem,

    input  logic                  i_br,
    input  logic [ADDR_W-1:0]     i_br_off,
    input  logic                  i_stall,

    output logic                  o_ifid_valid,
    output logic [31:0]           o_ifid_inst,
    output logic [ADDR_W-1:0]     o_ifid_pc,
    output logic                  o_misalign
);

    localparam logic [31:0]       NOP_INST   = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_KILL = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       r_skid_inst;
    logic [31:0]       w_skid_inst_nxt;
    logic              r_ifid_valid;
    logic              w_ifid_valid_nxt;
    logic [31:0]       r_ifid_inst;
    logic [31:0]       w_ifid_inst_nxt;
    logic [ADDR_W-1:0] r_ifid_pc;
    logic [ADDR_W-1:0] w_ifid_pc_nxt;
    logic              r_misalign;
    logic              w_misalign_nxt;

    logic              w_consume;
    logic              w_redirect;
    logic              w_ifid_free;
    logic              w_resp;
    logic [ADDR_W-1:0] w_target;

    // ID takes the IF/ID entry this cycle; a taken branch only counts then.
    assign w_consume   = r_ifid_valid & ~i_stall;
    assign w_redirect  = w_consume & i_br;
    assign w_ifid_free = ~r_ifid_valid | w_consume;
    assign w_resp      = imem.i_imem_valid;
    // Branch target wraps modulo 2^ADDR_W; no overflow indication.
    assign w_target    = r_ifid_pc + i_br_off;

    // Next-state, PC, skid and IF/ID update; a redirect overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_skid_inst_nxt  = r_skid_inst;
        w_ifid_valid_nxt = r_ifid_valid & ~w_consume;
        w_ifid_inst_nxt  = r_ifid_inst;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_misalign_nxt   = 1'b0;

        case (r_state)
            S_RST: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_resp) begin
                    if (w_ifid_free) begin
                        w_ifid_valid_nxt = 1'b1;
                        w_ifid_inst_nxt  = imem.i_imem_data;
                        w_ifid_pc_nxt    = r_pc;
                        w_pc_nxt         = r_pc + PC_STEP;
                        w_state_nxt      = S_REQ;
                    end else begin
                        // r_pc still names this instruction while it sits in the skid.
                        w_skid_inst_nxt  = imem.i_imem_data;
                        w_state_nxt      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_consume) begin
                    w_ifid_valid_nxt = 1'b1;
                    w_ifid_inst_nxt  = r_skid_inst;
                    w_ifid_pc_nxt    = r_pc;
                    w_pc_nxt         = r_pc + PC_STEP;
                    w_state_nxt      = S_REQ;
                end
            end
            S_KILL: begin
                if (w_resp) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase

        if (w_redirect) begin
            w_pc_nxt         = w_target & ALIGN_MASK;
            w_ifid_valid_nxt = 1'b0;
            w_skid_inst_nxt  = '0;
            w_misalign_nxt   = w_target[1];
            // A request already issued (or still pending) must be absorbed in
            // S_KILL; a response arriving this very cycle is simply dropped.
            if ((r_state == S_REQ) || ((r_state == S_WAIT) && !w_resp)) begin
                w_state_nxt = S_KILL;
            end else begin
                w_state_nxt = S_REQ;
            end
        end
    end

    // State, PC, skid and IF/ID registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_RST;
            r_pc         <= RESET_PC;
            r_skid_inst  <= '0;
            r_ifid_valid <= 1'b0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_pc    <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_skid_inst  <= w_skid_inst_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
            r_ifid_inst  <= w_ifid_inst_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_misalign   <= w_misalign_nxt;
        end
    end

    assign imem.o_imem_req  = (r_state == S_REQ);
    assign imem.o_imem_addr = r_pc;

    assign o_ifid_valid = r_ifid_valid;
    assign o_ifid_inst  = r_ifid_inst;
    assign o_ifid_pc    = r_ifid_pc;
    assign o_misalign   = r_misalign;

endmodule
